// File: rtl/deser_pkg.sv
// Shared defaults and state encoding for the serial-to-parallel deserializer.
package deser_pkg;

  localparam int DESER_WIDTH_DEF = 16;
  localparam int DESER_GAP_DEF   = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/deser_if.sv
// Serial input stream plus assembled-word output of the deserializer.
interface deser_if
  import deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEF
) ();

  localparam int MOD_W = $clog2(WIDTH);

  logic             ser_data_i;
  logic             ser_data_val_i;
  logic [WIDTH-1:0] deser_data_o;
  logic [MOD_W-1:0] deser_mod_o;
  logic             deser_data_val_o;
  logic             busy_o;

  modport master (
    output ser_data_i, ser_data_val_i,
    input  deser_data_o, deser_mod_o, deser_data_val_o, busy_o
  );

  modport slave (
    input  ser_data_i, ser_data_val_i,
    output deser_data_o, deser_mod_o, deser_data_val_o, busy_o
  );

endinterface

// File: rtl/deserializer_idle_timer.sv
// Counts consecutive idle ticks; expired_o pulses combinationally on the GAP_CYCLES-th one.
module idle_timer #(
  parameter int GAP_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] LAST = GW'(GAP_CYCLES - 1);

  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    expired_o = 1'b0;
    gap_d     = gap_q;
    if (clr_i) begin
      gap_d = '0;
    end else if (tick_i) begin
      if (gap_q == LAST) begin
        expired_o = 1'b1;
        gap_d     = '0;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/deserializer.sv
// Gathers an MSB-first serial stream into WIDTH-bit words; idle gaps flush partial words
// left-aligned with a bit count (0 = full word). Outputs registered, one cycle after the event.
module deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH      = DESER_WIDTH_DEF,
  parameter int GAP_CYCLES = DESER_GAP_DEF
) (
  input  logic    clk_i,
  input  logic    rst_n_i,
  deser_if.slave  bus
);

  localparam int MOD_W = $clog2(WIDTH);
  localparam logic [MOD_W-1:0] LAST_BIT = MOD_W'(WIDTH - 1);
  localparam logic [MOD_W:0]   FULL     = (MOD_W + 1)'(WIDTH);

  deser_state_t     state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [MOD_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [MOD_W-1:0] mod_q,   mod_d;
  logic             val_q,   val_d;
  logic             busy_q,  busy_d;

  logic             bit_vld;
  logic             gap_clr;
  logic             gap_tick;
  logic             gap_expired;
  logic [MOD_W:0]   align_shamt;
  logic [WIDTH-1:0] partial_word;

  assign bit_vld  = bus.ser_data_val_i;
  assign gap_clr  = (state_q == IDLE) || bit_vld;
  assign gap_tick = (state_q == COLLECT) && !bit_vld;

  idle_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_idle_timer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (gap_clr),
    .tick_i    (gap_tick),
    .expired_o (gap_expired)
  );

  // Partial words are flushed left-aligned so the first bit always sits at [WIDTH-1].
  assign align_shamt  = FULL - {1'b0, cnt_q};
  assign partial_word = shift_q << align_shamt;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bit_vld) begin
          shift_d = {{(WIDTH-1){1'b0}}, bus.ser_data_i};
          cnt_d   = MOD_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bit_vld) begin
          shift_d = {shift_q[WIDTH-2:0], bus.ser_data_i};
          if (cnt_q == LAST_BIT) begin
            data_d  = shift_d;
            mod_d   = '0;
            val_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + MOD_W'(1);
          end
        end else if (gap_expired) begin
          data_d  = partial_word;
          mod_d   = cnt_q;
          val_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.deser_data_o     = data_q;
  assign bus.deser_mod_o      = mod_q;
  assign bus.deser_data_val_o = val_q;
  assign bus.busy_o           = busy_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer (WIDTH=16, GAP_CYCLES=4) with hand-computed expectations.
module tb_deserializer;
  import deser_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;
  int   pulses  = 0;
  int   p0;

  deser_if bus ();

  deserializer dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Emit pulses are registered, so they are stable at the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.deser_data_val_o === 1'b1) pulses = pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.ser_data_i     = b;
    bus.ser_data_val_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, 32'(bus.deser_data_o), 32'h0);
    check({tag, "_mod"},  32'(bus.deser_mod_o), 32'h0);
    check({tag, "_val"},  32'(bus.deser_data_val_o), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'h0);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;
    #12;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // 1: one full word, then idle
    p0 = pulses;
    send_word(16'hA5C3);
    check("t1_val",  32'(bus.deser_data_val_o), 32'h1);
    check("t1_data", 32'(bus.deser_data_o), 32'hA5C3);
    check("t1_mod",  32'(bus.deser_mod_o), 32'h0);
    check("t1_busy", 32'(bus.busy_o), 32'h0);
    idle_step();
    check("t1_val_after", 32'(bus.deser_data_val_o), 32'h0);
    check("t1_data_hold", 32'(bus.deser_data_o), 32'hA5C3);
    for (int i = 0; i < 5; i++) idle_step();
    check("t1_pulses", 32'(pulses - p0), 32'h1);

    // 2: five bits 1,0,1,1,0 then a gap flush
    p0 = pulses;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("t2_busy", 32'(bus.busy_o), 32'h1);
    for (int i = 0; i < 3; i++) begin
      idle_step();
      check("t2_no_early_val", 32'(bus.deser_data_val_o), 32'h0);
    end
    idle_step();
    check("t2_val",  32'(bus.deser_data_val_o), 32'h1);
    check("t2_data", 32'(bus.deser_data_o), 32'hB000);
    check("t2_mod",  32'(bus.deser_mod_o), 32'h5);
    check("t2_busy_after", 32'(bus.busy_o), 32'h0);
    idle_step();
    check("t2_val_after", 32'(bus.deser_data_val_o), 32'h0);
    check("t2_pulses", 32'(pulses - p0), 32'h1);

    // 3: two words back to back, no dead cycle
    p0 = pulses;
    send_word(16'h1234);
    check("t3_val0",  32'(bus.deser_data_val_o), 32'h1);
    check("t3_data0", 32'(bus.deser_data_o), 32'h1234);
    check("t3_mod0",  32'(bus.deser_mod_o), 32'h0);
    send_word(16'h8001);
    check("t3_val1",  32'(bus.deser_data_val_o), 32'h1);
    check("t3_data1", 32'(bus.deser_data_o), 32'h8001);
    check("t3_mod1",  32'(bus.deser_mod_o), 32'h0);
    idle_step();
    check("t3_pulses", 32'(pulses - p0), 32'h2);

    // 4: gap one short of the limit must not flush
    p0 = pulses;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    for (int i = 0; i < 3; i++) idle_step();
    check("t4_no_flush_val", 32'(bus.deser_data_val_o), 32'h0);
    check("t4_busy_in_gap",  32'(bus.busy_o), 32'h1);
    for (int i = 0; i < 13; i++) send_bit(1'b1);
    check("t4_val",  32'(bus.deser_data_val_o), 32'h1);
    check("t4_data", 32'(bus.deser_data_o), 32'hFFFF);
    check("t4_mod",  32'(bus.deser_mod_o), 32'h0);
    idle_step();
    check("t4_pulses", 32'(pulses - p0), 32'h1);

    // 5: reset mid-word drops the partial word
    p0 = pulses;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    check("t5_busy_pre", 32'(bus.busy_o), 32'h1);
    bus.ser_data_val_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t5_reset");
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) idle_step();
    check("t5_no_stale_pulse", 32'(pulses - p0), 32'h0);
    send_word(16'h0F0F);
    check("t5_val",  32'(bus.deser_data_val_o), 32'h1);
    check("t5_data", 32'(bus.deser_data_o), 32'h0F0F);
    check("t5_mod",  32'(bus.deser_mod_o), 32'h0);
    idle_step();
    check("t5_pulses", 32'(pulses - p0), 32'h1);

    // 6: long idle after reset never flushes an empty word
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 100; i++) begin
      idle_step();
      check("t6_busy", 32'(bus.busy_o), 32'h0);
      check("t6_val",  32'(bus.deser_data_val_o), 32'h0);
    end
    check("t6_pulses", 32'(pulses - p0), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
